// File: rtl/db9_joy_responder.sv
// Far-end DB9/JAMMA joystick responder: a PISO shift chain driven by JOY_CLK/JOY_LOAD_N, oversampled on CLOCK_50.
// Optional macro DB9_CLK_FILTER_EN adds a 2-cycle stability filter on the synchronized JOY_CLK.
module db9_joy_responder #(
    parameter int   NBITS = 24,
    parameter logic FILL  = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [NBITS-1:0] joy_state,
    input  logic             JOY_CLK,
    input  logic             JOY_LOAD_N,
    output logic             JOY_DATA,
    output logic             frame_done,
    output logic             overrun,
    output logic [5:0]       bit_cnt
);
    localparam logic [5:0] NB   = 6'(NBITS);
    localparam logic [5:0] NBM1 = 6'(NBITS - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_DONE} state_e;

    logic             clk_meta_q, clk_s_q, clk_s_d_q;
    logic             load_meta_q, load_s_q;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             data_q, data_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             shift_ev;
    state_e           state;

`ifdef DB9_CLK_FILTER_EN
    logic filt_q, filt_d;

    // Filtered level follows clk_s only once it has held for two samples; the
    // edge fires in the cycle the filter is about to rise.
    always_comb begin
        filt_d   = (clk_s_q == clk_s_d_q) ? clk_s_q : filt_q;
        shift_ev = filt_d & ~filt_q & load_s_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) filt_q <= 1'b0;
        else       filt_q <= filt_d;
    end
`else
    always_comb shift_ev = clk_s_q & ~clk_s_d_q & load_s_q;
`endif

    always_comb begin
        if (!load_s_q)        state = ST_LOAD;
        else if (cnt_q == NB) state = ST_DONE;
        else                  state = ST_SHIFT;
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
        case (state)
            ST_LOAD: begin
                shreg_d = joy_state;
                cnt_d   = '0;
                ovr_d   = 1'b0;
            end
            ST_SHIFT: if (shift_ev) begin
                shreg_d = {shreg_q[NBITS-2:0], FILL};
                cnt_d   = cnt_q + 6'd1;
                done_d  = (cnt_q == NBM1);
            end
            ST_DONE: if (shift_ev) begin
                shreg_d = {shreg_q[NBITS-2:0], FILL};
                ovr_d   = 1'b1;
            end
            default: ;
        endcase
        data_d = shreg_d[NBITS-1];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b0;
            clk_s_q     <= 1'b0;
            clk_s_d_q   <= 1'b0;
            load_meta_q <= 1'b1;
            load_s_q    <= 1'b1;
            shreg_q     <= '1;
            data_q      <= 1'b1;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            clk_meta_q  <= JOY_CLK;
            clk_s_q     <= clk_meta_q;
            clk_s_d_q   <= clk_s_q;
            load_meta_q <= JOY_LOAD_N;
            load_s_q    <= load_meta_q;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    assign JOY_DATA   = data_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_db9_joy_responder.sv
// Directed bench for db9_joy_responder: load/shift frames, over-clock, load/clock overlap, reset, glitch.
module tb_db9_joy_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] joy_state = '0;
    logic        joy_clk = 1'b0;
    logic        joy_load_n = 1'b1;
    logic        joy_data, frame_done, overrun;
    logic [5:0]  bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int fd_base;

    // MSB-first serial image of 24'hA5F00F as read off the link.
    logic [23:0] seq_a5 = 24'b1010_0101_1111_0000_0000_1111;

    db9_joy_responder #(.NBITS(24), .FILL(1'b1)) dut (
        .CLOCK_50(clk), .reset(reset), .joy_state(joy_state),
        .JOY_CLK(joy_clk), .JOY_LOAD_N(joy_load_n),
        .JOY_DATA(joy_data), .frame_done(frame_done),
        .overrun(overrun), .bit_cnt(bit_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] w);
        joy_state  = w;
        joy_load_n = 1'b0;
        cyc(5);
        joy_load_n = 1'b1;
        cyc(5);
    endtask

    task automatic do_clk;
        joy_clk = 1'b1;
        cyc(5);
        joy_clk = 1'b0;
        cyc(5);
    endtask

    task automatic run_frame(input string tag);
        int k;
        logic exp_bit;
        fd_base = fd_cnt;
        do_load(24'hA5F00F);
        check({tag, "_bit0"}, 32'(joy_data), 32'(seq_a5[23]));
        for (k = 1; k <= 24; k++) begin
            do_clk();
            exp_bit = (k < 24) ? seq_a5[23-k] : 1'b1;
            check($sformatf("%s_bit%0d", tag, k), 32'(joy_data), 32'(exp_bit));
        end
        check({tag, "_cnt"}, 32'(bit_cnt), 32'd24);
        check({tag, "_fd"}, 32'(fd_cnt - fd_base), 32'd1);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #5 reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(6);
        check("rst_data", 32'(joy_data), 32'd1);
        check("rst_cnt", 32'(bit_cnt), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_fd", 32'(fd_cnt), 32'd0);

        run_frame("f1");

        do_clk();
        do_clk();
        check("oc_data", 32'(joy_data), 32'd1);
        check("oc_ovr", 32'(overrun), 32'd1);
        check("oc_cnt", 32'(bit_cnt), 32'd24);
        check("oc_fd", 32'(fd_cnt - fd_base), 32'd1);
        do_load(24'h000000);
        check("reld_ovr", 32'(overrun), 32'd0);
        check("reld_cnt", 32'(bit_cnt), 32'd0);
        check("reld_data", 32'(joy_data), 32'd0);

        // Clock rises while load is held low: that edge must be swallowed.
        joy_state  = 24'h800000;
        joy_load_n = 1'b0;
        cyc(2);
        joy_clk = 1'b1;
        cyc(5);
        joy_load_n = 1'b1;
        cyc(5);
        joy_clk = 1'b0;
        cyc(5);
        check("ovl_data", 32'(joy_data), 32'd1);
        check("ovl_cnt", 32'(bit_cnt), 32'd0);
        do_clk();
        check("ovl_shift1", 32'(joy_data), 32'd0);

        do_load(24'hA5F00F);
        for (int i = 0; i < 10; i++) do_clk();
        check("mid_cnt", 32'(bit_cnt), 32'd10);
        check("mid_data", 32'(joy_data), 32'(seq_a5[13]));
        reset = 1'b1;
        cyc(1);
        check("mrst_data", 32'(joy_data), 32'd1);
        check("mrst_cnt", 32'(bit_cnt), 32'd0);
        check("mrst_ovr", 32'(overrun), 32'd0);
        check("mrst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        cyc(4);
        run_frame("f2");

        do_load(24'h7FFFFF);
        check("gl_pre", 32'(joy_data), 32'd0);
`ifdef DB9_CLK_FILTER_EN
        joy_clk = 1'b1;
        cyc(1);
        joy_clk = 1'b0;
        cyc(8);
        check("gl_cnt", 32'(bit_cnt), 32'd0);
        check("gl_data", 32'(joy_data), 32'd0);
`else
        joy_clk = 1'b1;
        cyc(3);
        joy_clk = 1'b0;
        cyc(8);
        check("gl_cnt", 32'(bit_cnt), 32'd1);
        check("gl_data", 32'(joy_data), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
